// File: rtl/mic_level_meter_if.sv
// Sample/result bundle for the mic level meter: the mic sample in, the held peak, LED bar and clip flag out.
// master = sample source / display consumer, slave = the meter itself.
interface mic_level_meter_if #(
  parameter int w_mic = 24,
  parameter int w_led = 8
);
  logic [w_mic-1:0] mic;
  logic [w_mic-2:0] peak;
  logic [w_led-1:0] led;
  logic             clip;

  modport master (output mic, input peak, input led, input clip);
  modport slave  (input mic, output peak, output led, output clip);
endinterface

// File: rtl/mic_level_meter.sv
// Peak-hold mic level meter: |sample| peak with hold and 1/8 exponential decay, drives a thermometer LED bar.
// Latency: mic -> peak/clip 2 clk, mic -> led 3 clk.  No backpressure: accepts a sample every cycle.
// MIC_LEVEL_LOG_EN selects a 6 dB-per-LED log bar instead of the linear bar.
module mic_level_meter #(
  parameter int clk_mhz  = 27,
  parameter int w_mic    = 24,
  parameter int w_led    = 8,
  parameter int hold_ms  = 500,
  parameter int decay_us = 20000
) (
  input  logic           clk,
  input  logic           rst_n,
  mic_level_meter_if.slave bus
);

  localparam int HOLD_RAW = clk_mhz * 1000 * hold_ms;
  localparam int DEC_RAW  = clk_mhz * decay_us;
  localparam int HOLD_CYC = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
  localparam int DEC_CYC  = (DEC_RAW < 1) ? 1 : DEC_RAW;
  localparam int W_HOLD   = $clog2(HOLD_CYC + 1);
  localparam int W_DEC    = $clog2(DEC_CYC + 1);
  localparam int W_LV     = $clog2(w_led + 1);
  localparam int W_PROD   = w_mic + $clog2(w_led + 1);

  localparam logic [W_HOLD-1:0] HOLD_LOAD = W_HOLD'(HOLD_CYC - 1);
  localparam logic [W_DEC-1:0]  DEC_LAST  = W_DEC'(DEC_CYC - 1);
  localparam logic [w_mic-2:0]  FULL      = '1;

  logic [w_mic-1:0]  mic_r;
  logic [w_mic-1:0]  neg;
  logic [w_mic-2:0]  mag;
  logic [w_mic-2:0]  peak_q;
  logic [w_mic-2:0]  step;
  logic [W_HOLD-1:0] hold_cnt;
  logic [W_DEC-1:0]  decay_cnt;
  logic              clip_q;
  logic [W_LV-1:0]   level;
  logic [w_led-1:0]  led_nxt;
  logic [w_led-1:0]  led_q;

  // Only the most negative input leaves neg with its MSB set; saturate it to full scale.
  always_comb begin
    neg = -mic_r;
    if (!mic_r[w_mic-1])
      mag = mic_r[w_mic-2:0];
    else if (neg[w_mic-1])
      mag = FULL;
    else
      mag = neg[w_mic-2:0];
  end

  assign step = peak_q >> 3;

  always_comb begin
    int lvl;
`ifdef MIC_LEVEL_LOG_EN
    int msb;
    msb = -1;
    for (int i = 0; i < w_mic-1; i++)
      if (peak_q[i]) msb = i;
    lvl = msb - (w_mic - 1 - w_led) + 1;
`else
    logic [W_PROD-1:0] prod;
    prod = W_PROD'(peak_q) * W_PROD'(w_led + 1);
    lvl  = int'(prod >> (w_mic - 1));
`endif
    if (lvl < 0)     lvl = 0;
    if (lvl > w_led) lvl = w_led;
    level = W_LV'(lvl);
    for (int i = 0; i < w_led; i++)
      led_nxt[i] = (i < lvl);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mic_r     <= '0;
      peak_q    <= '0;
      hold_cnt  <= '0;
      decay_cnt <= '0;
      clip_q    <= 1'b0;
      led_q     <= '0;
    end else begin
      mic_r <= bus.mic;
      led_q <= led_nxt;
      if (mag > peak_q) begin
        peak_q    <= mag;
        hold_cnt  <= HOLD_LOAD;
        decay_cnt <= '0;
        clip_q    <= (mag == FULL);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - W_HOLD'(1);
        if (hold_cnt == W_HOLD'(1)) clip_q <= 1'b0;
      end else begin
        // Also covers a one-cycle hold, where the counter is loaded with zero.
        clip_q <= 1'b0;
        if (decay_cnt == DEC_LAST) begin
          decay_cnt <= '0;
          peak_q    <= (step == '0) ? '0 : peak_q - step;
        end else begin
          decay_cnt <= decay_cnt + W_DEC'(1);
        end
      end
    end
  end

  assign bus.peak = peak_q;
  assign bus.led  = led_q;
  assign bus.clip = clip_q;

endmodule
